// File: rtl/fp_issue_arbiter.sv
// Two-requester front end that serialises floating-point operations onto a single fp_unit.
// Define FP_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); otherwise round-robin.
module fp_issue_arbiter #(
   parameter int XLEN = 32,
   parameter int OPW  = 10
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [1:0]        req_valid,
   output logic [1:0]        req_ready,
   input  logic [2*XLEN-1:0] req_data1,
   input  logic [2*XLEN-1:0] req_data2,
   input  logic [2*XLEN-1:0] req_data3,
   input  logic [5:0]        req_rm,
   input  logic [2*OPW-1:0]  req_opcode,
   input  logic [3:0]        req_cvt_op,
   output logic              fpu_enable,
   output logic [XLEN-1:0]   fpu_data1,
   output logic [XLEN-1:0]   fpu_data2,
   output logic [XLEN-1:0]   fpu_data3,
   output logic [2:0]        fpu_rm,
   output logic [OPW-1:0]    fpu_opcode,
   output logic [1:0]        fpu_cvt_op,
   input  logic [XLEN-1:0]   fpu_result,
   input  logic [4:0]        fpu_flags,
   input  logic              fpu_ready,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic              resp_id,
   output logic [XLEN-1:0]   resp_result,
   output logic [4:0]        resp_flags,
   output logic              busy
);

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

   state_t          state_reg;
   logic            fpu_enable_reg;
   logic [XLEN-1:0] fpu_data1_reg;
   logic [XLEN-1:0] fpu_data2_reg;
   logic [XLEN-1:0] fpu_data3_reg;
   logic [2:0]      fpu_rm_reg;
   logic [OPW-1:0]  fpu_opcode_reg;
   logic [1:0]      fpu_cvt_op_reg;
   logic            resp_valid_reg;
   logic            resp_id_reg;
   logic [XLEN-1:0] resp_result_reg;
   logic [4:0]      resp_flags_reg;

   logic [XLEN-1:0] data1_arr  [2];
   logic [XLEN-1:0] data2_arr  [2];
   logic [XLEN-1:0] data3_arr  [2];
   logic [2:0]      rm_arr     [2];
   logic [OPW-1:0]  opcode_arr [2];
   logic [1:0]      cvt_arr    [2];

   logic            grant_idx;
   logic            accept;
   logic            op_legal;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
         assign data1_arr[gi]  = req_data1[gi*XLEN +: XLEN];
         assign data2_arr[gi]  = req_data2[gi*XLEN +: XLEN];
         assign data3_arr[gi]  = req_data3[gi*XLEN +: XLEN];
         assign rm_arr[gi]     = req_rm[gi*3 +: 3];
         assign opcode_arr[gi] = req_opcode[gi*OPW +: OPW];
         assign cvt_arr[gi]    = req_cvt_op[gi*2 +: 2];
      end
   endgenerate

`ifdef FP_ARB_FIXED_PRIO_EN
   always_comb begin
      grant_idx = !req_valid[0];
   end
`else
   logic rr_ptr_reg;

   always_comb begin
      case (req_valid)
         2'b10:   grant_idx = 1'b1;
         2'b11:   grant_idx = rr_ptr_reg;
         default: grant_idx = 1'b0;
      endcase
   end

   // Pointer hands priority to the other requester after every grant.
   always_ff @(posedge clock) begin
      if (reset) begin
         rr_ptr_reg <= 1'b0;
      end else if (accept) begin
         rr_ptr_reg <= ~grant_idx;
      end
   end
`endif

   assign accept   = (state_reg == ST_IDLE) && (|req_valid) && !reset;
   assign op_legal = $onehot(opcode_arr[grant_idx]);

   always_comb begin
      req_ready = 2'b00;
      if (accept) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   // Malformed opcodes never reach the fp_unit; they answer directly with NV.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg       <= ST_IDLE;
         fpu_enable_reg  <= 1'b0;
         fpu_data1_reg   <= '0;
         fpu_data2_reg   <= '0;
         fpu_data3_reg   <= '0;
         fpu_rm_reg      <= '0;
         fpu_opcode_reg  <= '0;
         fpu_cvt_op_reg  <= '0;
         resp_valid_reg  <= 1'b0;
         resp_id_reg     <= 1'b0;
         resp_result_reg <= '0;
         resp_flags_reg  <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (accept) begin
                  resp_id_reg <= grant_idx;
                  if (op_legal) begin
                     fpu_data1_reg  <= data1_arr[grant_idx];
                     fpu_data2_reg  <= data2_arr[grant_idx];
                     fpu_data3_reg  <= data3_arr[grant_idx];
                     fpu_rm_reg     <= rm_arr[grant_idx];
                     fpu_opcode_reg <= opcode_arr[grant_idx];
                     fpu_cvt_op_reg <= cvt_arr[grant_idx];
                     fpu_enable_reg <= 1'b1;
                     state_reg      <= ST_ISSUE;
                  end else begin
                     resp_result_reg <= '0;
                     resp_flags_reg  <= 5'b10000;
                     resp_valid_reg  <= 1'b1;
                     state_reg       <= ST_RESP;
                  end
               end
            end
            ST_ISSUE: begin
               fpu_enable_reg <= 1'b0;
               state_reg      <= ST_WAIT;
            end
            ST_WAIT: begin
               if (fpu_ready) begin
                  resp_result_reg <= fpu_result;
                  resp_flags_reg  <= fpu_flags;
                  resp_valid_reg  <= 1'b1;
                  state_reg       <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (resp_ready) begin
                  resp_valid_reg <= 1'b0;
                  state_reg      <= ST_IDLE;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign fpu_enable  = fpu_enable_reg;
   assign fpu_data1   = fpu_data1_reg;
   assign fpu_data2   = fpu_data2_reg;
   assign fpu_data3   = fpu_data3_reg;
   assign fpu_rm      = fpu_rm_reg;
   assign fpu_opcode  = fpu_opcode_reg;
   assign fpu_cvt_op  = fpu_cvt_op_reg;
   assign resp_valid  = resp_valid_reg;
   assign resp_id     = resp_id_reg;
   assign resp_result = resp_result_reg;
   assign resp_flags  = resp_flags_reg;
   assign busy        = (state_reg != ST_IDLE);

endmodule

// File: doc/fp_issue_arbiter.md
FP_ISSUE_ARBITER -- requirements
Module: fp_issue_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width.
REQ-002 SHALL have parameter OPW, default 10, one-hot opcode width (bit0 fmadd, 1 fadd, 2 fsub, 3 fmul, 4 fdiv, 5 fsqrt, 6 fcmp, 8 fcvt_i2f, 9 fcvt_f2i).
REQ-003 SHALL have ports, in order:
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  2  per-requester request
- req_ready  out  2  per-requester accept
- req_data1 / req_data2 / req_data3  in  2*XLEN each  operands, requester i at [i*XLEN +: XLEN]
- req_rm  in  2*3  rounding mode
- req_opcode  in  2*OPW  one-hot operation
- req_cvt_op  in  2*2  conversion sub-op
- fpu_enable  out  1  issue strobe to fp_unit
- fpu_data1 / fpu_data2 / fpu_data3  out  XLEN each  issued operands
- fpu_rm  out  3 ; fpu_opcode  out  OPW ; fpu_cvt_op  out  2
- fpu_result  in  XLEN ; fpu_flags  in  5 ; fpu_ready  in  1  completion from fp_unit
- resp_valid  out  1 ; resp_ready  in  1  response handshake
- resp_id  out  1  requester owning response
- resp_result  out  XLEN ; resp_flags  out  5
- busy  out  1  high in any state except IDLE

Function
REQ-004 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE; one operation outstanding at a time.
REQ-005 IDLE: if any req_valid, SHALL pick grant g by arbitration (REQ-012), assert req_ready[g] combinationally in that cycle only, register g's payload and go ISSUE; req_ready SHALL be 0 in every other state and for the non-granted requester.
REQ-006 Payload whose opcode is zero or not one-hot SHALL skip ISSUE/WAIT: go RESP with resp_result=0, resp_flags=5'b10000 (NV); fpu_enable SHALL stay 0.
REQ-007 ISSUE: fpu_enable=1 for exactly one cycle; next state WAIT.
REQ-008 fpu_data*/fpu_rm/fpu_opcode/fpu_cvt_op SHALL be driven from registers and held stable from ISSUE until leaving WAIT.
REQ-009 WAIT: fpu_ready SHALL be sampled only here; on fpu_ready=1 register fpu_result/fpu_flags into resp_result/resp_flags and go RESP; no timeout.
REQ-010 RESP: resp_valid=1 with resp_id=g; outputs stable until resp_ready=1 sampled, then go IDLE; new request accepted no earlier than the following cycle.
REQ-011 Minimum accept-to-resp_valid latency: 3 cycles (accept t, enable t+1, fpu_ready at t+2, resp_valid t+3).
REQ-012 Default arbitration: round-robin; pointer initialised to 0; on grant pointer := other requester; with both valid, pointer's requester wins; single valid requester always wins.
REQ-013 fpu_ready asserted in IDLE, ISSUE or RESP SHALL be ignored.

Reset
REQ-014 reset=1 at a rising edge SHALL force IDLE, RR pointer=0, req_ready=0, fpu_enable=0, resp_valid=0, busy=0, resp_id=0, and zero all fpu_* and resp_* data outputs.
REQ-015 Reset mid-operation SHALL drop the in-flight op with no response; completion pulses from it are ignored per REQ-013.

Configuration
REQ-016 Macro FP_ARB_FIXED_PRIO_EN defined: requester 0 SHALL always win when both valid; RR pointer not implemented. Undefined: round-robin per REQ-012.

Verification
REQ-017 Both valid at IDLE after reset, fadd 0x3F800000+0x40000000, fpu_ready 2 cycles after enable -> grant 0, fpu_enable one pulse, resp_id=0, resp_result=0x40400000 echoed from fpu_result.
REQ-018 Both valid continuously, 4 ops, RR build -> resp_id sequence 0,1,0,1; FP_ARB_FIXED_PRIO_EN build -> 0,0,0,0.
REQ-019 req_opcode=0 or 0x006 -> no fpu_enable, resp_result=0, resp_flags=10000 one cycle after accept.
REQ-020 fdiv with fpu_ready delayed 20 cycles, resp_ready held 0 for 5 cycles -> fpu_* stable 20 cycles, resp_* stable until handshake, req_ready=0 throughout.
REQ-021 Reset asserted during WAIT, fpu_ready pulse afterwards -> FSM IDLE, no resp_valid, pointer=0.
REQ-022 Spurious fpu_ready in IDLE and in RESP -> no state change, resp_result unchanged.
